// File: rtl/acc_rr_arbiter.sv
// Round-robin front end that shares one acc_pipe among N_REQ requesters.
// An in-order tag FIFO steers each acc_pipe result back to the requester that issued it.
module acc_rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DW       = 8,
  parameter int MAX_INFL = 8
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*4*DW-1:0]     req_data,
  output logic [N_REQ-1:0]          rsp_valid,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic [DW-1:0]             rsp_y,
  output logic [DW-1:0]             acc_X1,
  output logic [DW-1:0]             acc_X2,
  output logic [DW-1:0]             acc_X3,
  output logic [DW-1:0]             acc_X4,
  output logic                      acc_valid,
  input  logic                      acc_ready,
  input  logic [DW-1:0]             acc_Y,
  input  logic                      acc_valid_out,
  output logic                      acc_ready_out,
  output logic [$clog2(MAX_INFL):0] inflight,
  output logic                      err_orphan
);

  localparam int TW = $clog2(N_REQ);
  localparam int AW = (MAX_INFL > 1) ? $clog2(MAX_INFL) : 1;
  localparam int CW = $clog2(MAX_INFL) + 1;

  logic [TW-1:0] rr_ptr_q, rr_ptr_d;
  logic [TW-1:0] grant_q, grant_d;
  logic          lock_q, lock_d;
  logic [TW-1:0] fifo_q [MAX_INFL];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [TW-1:0] rr_pick;
  logic [TW:0]   scan;
  logic [TW-1:0] grant;
  logic [TW-1:0] head;
  logic          full, empty, push, pop;

  // Scan downward so the requester closest to rr_ptr is the last one written.
  always_comb begin
    rr_pick = rr_ptr_q;
    scan    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan = {1'b0, rr_ptr_q} + (TW+1)'(k);
      if (scan >= (TW+1)'(N_REQ)) scan = scan - (TW+1)'(N_REQ);
      if (req_valid[scan[TW-1:0]]) rr_pick = scan[TW-1:0];
    end
  end

  assign grant = lock_q ? grant_q : rr_pick;
  assign full  = (cnt_q == CW'(MAX_INFL));
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rd_ptr_q];

  assign acc_valid = !arst && (|req_valid) && !full;
  assign push      = acc_valid && acc_ready;
  assign {acc_X4, acc_X3, acc_X2, acc_X1} = req_data[int'(grant)*4*DW +: 4*DW];

  assign acc_ready_out = !arst && !empty && rsp_ready[head];
  assign pop           = acc_valid_out && acc_ready_out;
  assign rsp_y         = acc_Y;
  assign inflight      = cnt_q;
  assign err_orphan    = err_q;

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (push) req_ready[grant] = 1'b1;
    if (!arst && acc_valid_out && !empty) rsp_valid[head] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    lock_d   = lock_q;
    grant_d  = grant;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q | (acc_valid_out && empty);
    if (push) begin
      rr_ptr_d = (grant == TW'(N_REQ - 1)) ? '0 : grant + TW'(1);
      lock_d   = 1'b0;
      wr_ptr_d = (wr_ptr_q == AW'(MAX_INFL - 1)) ? '0 : wr_ptr_q + AW'(1);
    end else if (acc_valid) begin
      // Offer stays pinned to this requester until acc_pipe takes it.
      lock_d = 1'b1;
    end
    if (pop) rd_ptr_d = (rd_ptr_q == AW'(MAX_INFL - 1)) ? '0 : rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rr_ptr_q <= '0;
      grant_q  <= '0;
      lock_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < MAX_INFL; i++) fifo_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      lock_q   <= lock_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      if (push) fifo_q[wr_ptr_q] <= grant;
    end
  end

endmodule

// File: tb/tb_acc_rr_arbiter.sv
// Randomized bench for acc_rr_arbiter with a queue-based acc_pipe stand-in.
// A monitor compares every cycle against a round-robin/scoreboard reference model.
module tb_acc_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MI = 8;

  logic              clk = 1'b0;
  logic              arst;
  logic [N-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*4*DW-1:0] req_data;
  logic [DW-1:0]     rsp_y, acc_X1, acc_X2, acc_X3, acc_X4, acc_Y;
  logic              acc_valid, acc_ready, acc_valid_out, acc_ready_out, err_orphan;
  logic [$clog2(MI):0] inflight;

  always #5 clk = ~clk;

  acc_rr_arbiter #(.N_REQ(N), .DW(DW), .MAX_INFL(MI)) dut (
    .clk(clk), .arst(arst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .acc_X1(acc_X1), .acc_X2(acc_X2), .acc_X3(acc_X3), .acc_X4(acc_X4),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_Y(acc_Y),
    .acc_valid_out(acc_valid_out), .acc_ready_out(acc_ready_out),
    .inflight(inflight), .err_orphan(err_orphan)
  );

  typedef struct { int r; logic [7:0] y; } exp_t;
  typedef struct { logic [7:0] y; int t; } pq_t;
  exp_t sb[$];
  pq_t  pq[$];

  int n_chk = 0, n_pass = 0;
  int rr_m, grant_m, cnt_m, cyc;
  bit lock_m, err_m;
  int acc_cnt[N], seen_cnt[N], gcount[N];
  int gseq[$];
  bit pend[N];
  logic [31:0] dat[N];
  int gen_p, ar_p;
  bit rsp_rand, force_vo;
  logic [N-1:0] rsp_fix;

  function automatic logic [7:0] golden(input logic [31:0] d);
    return d[7:0] + d[15:8] + d[23:16] + d[31:24];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_data[i*32 +: 32] = dat[i];
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (acc_cnt[i] != seen_cnt[i]) begin
        seen_cnt[i] = acc_cnt[i];
        pend[i] = 1'b0;
      end
      if (!pend[i] && gen_p > 0 && int'($urandom_range(0, 99)) < gen_p) begin
        pend[i] = 1'b1;
        dat[i]  = $urandom;
      end
    end
    acc_ready = (ar_p >= 100) || (int'($urandom_range(0, 99)) < ar_p);
    rsp_ready = rsp_rand ? N'($urandom) : rsp_fix;
    apply();
  endtask

  task automatic wait_drain(input string nm);
    bit done;
    gen_p = 0; ar_p = 100; rsp_rand = 0; rsp_fix = '1;
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      step();
      done = (sb.size() == 0) && (pq.size() == 0) && (inflight == 0);
      for (int i = 0; i < N; i++) if (pend[i]) done = 0;
    end
    chk({nm, "_drained"}, 64'(done), 64'd1);
    chk({nm, "_inflight0"}, 64'(inflight), 64'd0);
  endtask

  initial begin
    arst = 1'b0; acc_ready = 1'b0; rsp_ready = '1; acc_valid_out = 1'b0; acc_Y = '0;
    gen_p = 0; ar_p = 100; rsp_rand = 0; rsp_fix = '1; force_vo = 0; cyc = 0;
    rr_m = 0; grant_m = 0; cnt_m = 0; lock_m = 0; err_m = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1; dat[i] = $urandom; acc_cnt[i] = 0; seen_cnt[i] = 0; gcount[i] = 0;
    end
    apply();
    #2 arst = 1'b1;

    fork
      // Monitor / reference model
      begin
        int g, hd, idx;
        bit eav, earo;
        logic [N-1:0] erv, err;
        forever begin
          @(negedge clk);
          if (arst) begin
            chk("rst_acc_valid", 64'(acc_valid), 0);
            chk("rst_req_ready", 64'(req_ready), 0);
            chk("rst_rsp_valid", 64'(rsp_valid), 0);
            chk("rst_acc_ready_out", 64'(acc_ready_out), 0);
            chk("rst_inflight", 64'(inflight), 0);
            chk("rst_err_orphan", 64'(err_orphan), 0);
            rr_m = 0; lock_m = 0; cnt_m = 0; err_m = 0; sb.delete();
          end else begin
            g = -1;
            if (lock_m) begin
              g = grant_m;
              chk("locked_req_held", 64'(req_valid[grant_m]), 64'd1);
            end else begin
              for (int k = 0; k < N; k++) begin
                idx = (rr_m + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
              end
            end
            eav = (req_valid != 0) && (cnt_m < MI);
            chk("acc_valid", 64'(acc_valid), 64'(eav));
            err = (eav && acc_ready) ? N'(1 << g) : '0;
            chk("req_ready", 64'(req_ready), 64'(err));
            if (eav) chk("acc_X", 64'({acc_X4, acc_X3, acc_X2, acc_X1}), 64'(dat[g]));

            hd   = (sb.size() > 0) ? sb[0].r : -1;
            erv  = (acc_valid_out && hd >= 0) ? N'(1 << hd) : '0;
            earo = (hd >= 0) && rsp_ready[hd];
            chk("rsp_valid", 64'(rsp_valid), 64'(erv));
            chk("acc_ready_out", 64'(acc_ready_out), 64'(earo));
            chk("err_orphan", 64'(err_orphan), 64'(err_m));
            chk("inflight", 64'(inflight), 64'(cnt_m));

            if (acc_valid_out && earo) begin
              chk("rsp_y", 64'(rsp_y), 64'(sb[0].y));
              void'(sb.pop_front());
              cnt_m--;
            end
            if (acc_valid_out && hd < 0) err_m = 1;
            for (int i = 0; i < N; i++) if (req_ready[i]) begin gcount[i]++; gseq.push_back(i); end
            if (eav && acc_ready) begin
              sb.push_back('{g, golden(dat[g])});
              acc_cnt[g]++;
              rr_m = (g + 1) % N; lock_m = 0; cnt_m++;
            end else if (eav) begin
              lock_m = 1; grant_m = g;
            end
          end
        end
      end
      // acc_pipe stand-in: in-order, 1..3 cycle latency, Y = X1+X2+X3+X4
      begin
        bit fin, fout;
        logic [31:0] xin;
        int t;
        forever begin
          @(negedge clk);
          fin  = acc_valid && acc_ready;
          fout = acc_valid_out && acc_ready_out;
          xin  = {acc_X4, acc_X3, acc_X2, acc_X1};
          @(posedge clk); cyc++; #1;
          if (arst) pq.delete();
          else begin
            if (fout && pq.size() > 0) void'(pq.pop_front());
            if (fin) begin
              t = cyc + int'($urandom_range(1, 3));
              if (pq.size() > 0 && pq[$].t > t) t = pq[$].t;
              pq.push_back('{golden(xin), t});
            end
          end
          if (force_vo) begin acc_valid_out = 1'b1; acc_Y = 8'h5A; end
          else if (pq.size() > 0 && pq[0].t <= cyc) begin acc_valid_out = 1'b1; acc_Y = pq[0].y; end
          else begin acc_valid_out = 1'b0; acc_Y = '0; end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    apply();
    #3 arst = 1'b0;

    // single request {X4..X1} = {4,3,2,1}
    pend[0] = 1'b1; dat[0] = 32'h04030201; acc_ready = 1'b1; apply();
    @(negedge clk);
    chk("t1_same_cycle_ready", 64'(req_ready), 64'd1);
    wait_drain("t1");

    // all requesters saturating: 25 transfers each out of 100
    for (int i = 0; i < N; i++) gcount[i] = 0;
    gen_p = 100; ar_p = 100; rsp_fix = '1;
    begin
      int tot, snap[N];
      tot = 0;
      for (int c = 0; c < 300 && tot < 100; c++) begin
        step();
        tot = 0;
        for (int i = 0; i < N; i++) tot += gcount[i];
      end
      for (int i = 0; i < N; i++) snap[i] = gcount[i];
      chk("t2_total", 64'(tot), 64'd100);
      for (int i = 0; i < N; i++) chk($sformatf("t2_share%0d", i), 64'(snap[i]), 64'd25);
    end
    wait_drain("t2");

    // stalled grant to req1 must hold while others arrive
    ar_p = 0; step();
    pend[1] = 1'b1; dat[1] = $urandom; apply();
    step();
    pend[0] = 1'b1; pend[2] = 1'b1; pend[3] = 1'b1;
    dat[0] = $urandom; dat[2] = $urandom; dat[3] = $urandom; apply();
    repeat (3) step();
    @(negedge clk);
    chk("t3_held_X", 64'({acc_X4, acc_X3, acc_X2, acc_X1}), 64'(dat[1]));
    chk("t3_no_ready", 64'(req_ready), 64'd0);
    gseq.delete();
    ar_p = 100;
    for (int c = 0; c < 20 && gseq.size() < 4; c++) step();
    chk("t3_grants", 64'(gseq.size()), 64'd4);
    if (gseq.size() >= 4) begin
      chk("t3_g0", 64'(gseq[0]), 64'd1);
      chk("t3_g1", 64'(gseq[1]), 64'd2);
      chk("t3_g2", 64'(gseq[2]), 64'd3);
      chk("t3_g3", 64'(gseq[3]), 64'd0);
    end
    wait_drain("t3");

    // stalled head requester backs up to a full FIFO
    rsp_fix = 4'b1011; ar_p = 100; step();
    pend[2] = 1'b1; dat[2] = $urandom; apply();
    gen_p = 100;
    begin
      bit hit;
      hit = 0;
      for (int c = 0; c < 60 && !hit; c++) begin
        step();
        hit = (inflight == MI);
      end
      chk("t4_reached_full", 64'(hit), 64'd1);
    end
    @(negedge clk);
    chk("t4_full_acc_valid", 64'(acc_valid), 64'd0);
    chk("t4_head_stall", 64'(acc_ready_out), 64'd0);
    wait_drain("t4");

    // orphan result with empty FIFO
    force_vo = 1; step(); step();
    @(negedge clk);
    chk("t5_orphan_aro", 64'(acc_ready_out), 64'd0);
    chk("t5_orphan_rsp_valid", 64'(rsp_valid), 64'd0);
    force_vo = 0;
    repeat (5) step();
    chk("t5_err_sticky", 64'(err_orphan), 64'd1);

    // reset with five results outstanding
    rsp_fix = '0; ar_p = 100; gen_p = 100;
    begin
      bit hit;
      hit = 0;
      for (int c = 0; c < 40 && !hit; c++) begin
        step();
        hit = (inflight == 5);
      end
      chk("t6_reached5", 64'(hit), 64'd1);
    end
    gen_p = 0;
    #2 arst = 1'b1;
    #1;
    chk("t6_acc_valid", 64'(acc_valid), 64'd0);
    chk("t6_req_ready", 64'(req_ready), 64'd0);
    chk("t6_inflight", 64'(inflight), 64'd0);
    chk("t6_err_cleared", 64'(err_orphan), 64'd0);
    step(); step();
    rsp_fix = '1;
    for (int i = 0; i < N; i++) pend[i] = 1'b1;
    apply();
    @(posedge clk); #3 arst = 1'b0;
    gseq.delete();
    for (int c = 0; c < 10 && gseq.size() == 0; c++) step();
    chk("t6_first_after_rst", 64'(gseq.size() > 0 ? gseq[0] : -1), 64'd0);
    wait_drain("t6");

    // random traffic
    gen_p = 30; ar_p = 70; rsp_rand = 1;
    repeat (1500) step();
    wait_drain("t7");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
